// File: rtl/seq_barrel_shifter_if.sv
// seq_barrel_shifter_if: start/busy/done handshake and operand/result bus for seq_barrel_shifter
interface seq_barrel_shifter_if #(
  parameter int WIDTH = 12,
  parameter int SHW = 4
);
  logic start;
  logic [1:0] mode;
  logic [SHW-1:0] amt;
  logic [WIDTH-1:0] din;
  logic busy;
  logic done;
  logic [WIDTH-1:0] dout;
  logic sticky;
  modport master (output start, mode, amt, din, input busy, done, dout, sticky);
  modport slave (input start, mode, amt, din, output busy, done, dout, sticky);
endinterface

// File: rtl/seq_barrel_shifter.sv
// seq_barrel_shifter: one 2^k stage per clock log shifter (LSR/ASR/LSL/ROR, sticky); ports clk, rst, bus.slave (start/mode/amt/din in, busy/done/dout/sticky out)
module seq_barrel_shifter #(
  parameter int WIDTH = 12,
  parameter int SHW = 4
) (
  input logic clk,
  input logic rst,
  seq_barrel_shifter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHW-1:0] LAST = (SHW)'(SHW - 1);
  state_t state_q;
  logic [WIDTH-1:0] work_q, work_d, dout_q, asr, shifted, mask;
  logic [SHW-1:0] amt_q, stage_q;
  logic [1:0] mode_q;
  logic busy_q, done_q, sticky_q, sticky_d;
  logic [31:0] sh, rot;
  always_comb begin
    sh = 32'd1 << stage_q;
    rot = sh % 32'(WIDTH);
    mask = ~({WIDTH{1'b1}} << sh);
    asr = $signed(work_q) >>> sh;
    shifted = mode_q == 2'b00 ? work_q >> sh :
              mode_q == 2'b01 ? asr :
              mode_q == 2'b10 ? work_q << sh :
              (work_q >> rot) | (work_q << (32'(WIDTH) - rot));
    work_d = amt_q[0] ? shifted : work_q;
    sticky_d = sticky_q | (amt_q[0] & ~mode_q[1] & |(work_q & mask));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
      sticky_q <= 1'b0;
      stage_q <= '0;
      work_q <= '0;
      amt_q <= '0;
      mode_q <= 2'b00;
    end else begin
      case (state_q)
        SHIFT: begin
          work_q <= work_d;
          amt_q <= amt_q >> 1;
          sticky_q <= sticky_d;
          stage_q <= stage_q + 1'b1;
          if (stage_q == LAST) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dout_q <= work_d;
          end
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= bus.start;
          state_q <= bus.start ? SHIFT : IDLE;
          if (bus.start) begin
            work_q <= bus.din;
            amt_q <= bus.amt;
            mode_q <= bus.mode;
            sticky_q <= 1'b0;
            stage_q <= '0;
          end
        end
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.sticky = sticky_q;
endmodule

// File: tb/tb_seq_barrel_shifter.sv
// tb_seq_barrel_shifter: scoreboard bench for seq_barrel_shifter with directed vectors
module tb_seq_barrel_shifter;
  typedef struct packed {logic [11:0] d; logic s;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  int dones = 0;
  exp_t q[$];
  seq_barrel_shifter_if #(.WIDTH(12), .SHW(4)) bus ();
  seq_barrel_shifter #(.WIDTH(12), .SHW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      dones++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", 32'(bus.dout), 32'(e.d));
        chk("sticky", 32'(bus.sticky), 32'(e.s));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic [1:0] m, input logic [3:0] a, input logic [11:0] d);
    bus.start = s;
    bus.mode = m;
    bus.amt = a;
    bus.din = d;
  endtask
  task automatic wait_done(input string nm, input int exp_cyc);
    int b = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      b += int'(bus.busy);
      step();
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_busy_cycles"}, 32'(b), 32'(exp_cyc - cyc + 4 + (cyc - exp_cyc)));
  endtask
  task automatic op(input string nm, input logic [1:0] m, input logic [3:0] a, input logic [11:0] d,
                    input logic [11:0] ed, input logic es);
    int n;
    n = cyc;
    drive(1'b1, m, a, d);
    q.push_back({ed, es});
    step();
    drive(1'b0, ~m, ~a, ~d);
    wait_done(nm, n + 5);
  endtask
  initial begin
    int n;
    drive(1'b0, 2'b00, 4'd0, 12'h000);
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_sticky", 32'(bus.sticky), 0);
    step();
    op("lsr3", 2'b00, 4'd3, 12'hB5C, 12'h16B, 1'b1);
    op("asr11a", 2'b01, 4'd11, 12'h800, 12'hFFF, 1'b0);
    op("asr11b", 2'b01, 4'd11, 12'h801, 12'hFFF, 1'b1);
    op("lsl5", 2'b10, 4'd5, 12'h0F0, 12'hE00, 1'b0);
    op("lsl0", 2'b10, 4'd0, 12'h0F0, 12'h0F0, 1'b0);
    op("ror13", 2'b11, 4'd13, 12'h001, 12'h800, 1'b0);
    op("ror12", 2'b11, 4'd12, 12'hABC, 12'hABC, 1'b0);
    op("lsr0", 2'b00, 4'd0, 12'hFFF, 12'hFFF, 1'b0);
    step();
    n = cyc;
    drive(1'b1, 2'b01, 4'd2, 12'h9A4);
    q.push_back({12'hE69, 1'b0});
    step();
    drive(1'b0, 2'b00, 4'd0, 12'h000);
    step();
    drive(1'b1, 2'b10, 4'd1, 12'h123);
    step();
    drive(1'b1, 2'b11, 4'd7, 12'h456);
    step();
    drive(1'b0, 2'b00, 4'd0, 12'h000);
    step();
    chk("hs_done_cycle", 32'(bus.done), 1);
    drive(1'b1, 2'b00, 4'd4, 12'h0FF);
    q.push_back({12'h00F, 1'b1});
    step();
    drive(1'b0, 2'b00, 4'd0, 12'h000);
    wait_done("b2b", n + 10);
    step();
    n = dones;
    drive(1'b1, 2'b00, 4'd15, 12'hFFF);
    step();
    drive(1'b0, 2'b00, 4'd0, 12'h000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_dout", 32'(bus.dout), 0);
    chk("mid_rst_sticky", 32'(bus.sticky), 0);
    for (int i = 0; i < 8; i++) step();
    chk("mid_rst_no_done", 32'(dones - n), 0);
    op("after_rst", 2'b11, 4'd4, 12'h123, 12'h312, 1'b0);
    step();
    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seq_barrel_shifter.md
Name: seq_barrel_shifter

Overview:
- Parametrised, multi-cycle logarithmic barrel shifter; successor to the fixed 12-bit, shift-by-one mux stage.
- Applies one power-of-two stage per clock: stage k shifts by 2^k when amt[k] is set.
- Supports logical right, arithmetic right, logical left and rotate right.
- Produces a sticky bit for floating-point mantissa alignment and uses a start/busy/done handshake toward the datapath controller.

Parameters:
WIDTH, 12, data width in bits (>=2)
SHW, 4, shift-amount width; number of stages and shift cycles

Ports:
clk     input   1      rising-edge clock
rst     input   1      synchronous active-high reset
start   input   1      request; sampled only when not busy
mode    input   2      00 LSR, 01 ASR, 10 LSL, 11 ROR; latched on accept
amt     input   SHW    shift amount 0..2^SHW-1; latched on accept
din     input   WIDTH  operand; latched on accept
busy    output  1      high while stages are being applied
done    output  1      one-cycle pulse; dout/sticky valid
dout    output  WIDTH  result; held until next accept or reset
sticky  output  1      OR of all bits shifted out (LSR/ASR only)

Behaviour:
- Reset (rst=1 at a rising edge, synchronous): state=IDLE, busy=0, done=0, dout=0, sticky=0, stage counter=0. Reset overrides any in-flight operation. Result is discarded and no done is issued.
- States are IDLE, SHIFT and DONE.
- IDLE or DONE, start=1: latch din into the work register, latch amt and mode, clear sticky, set stage=0, go to SHIFT.
- DONE, start=0: go to IDLE.
- start is accepted in the DONE cycle, so back-to-back operations are allowed.
- SHIFT, each cycle, with stage k and s=2^k:
  - If amt[k]=0: work register unchanged.
  - LSR: work = work >> s, zero fill.
  - ASR: work = work >> s, filled with the MSB of the current work register.
  - LSL: work = work << s, zero fill, upper bits discarded.
  - ROR: work rotated right by s.
  - LSR/ASR: sticky |= OR of the s low bits dropped. If s >= WIDTH, all WIDTH bits count as dropped.
  - LSL/ROR: sticky stays 0.
  - Shifts with s >= WIDTH: LSR/LSL give 0; ASR gives all MSB.
- After stage SHW-1: go to DONE. done=1 for exactly that cycle, and dout holds the final work value.
- Timing: start sampled in cycle 0. busy=1 in cycles 1..SHW. done=1 in cycle SHW+1. Fixed latency, independent of amt.
- start while busy=1: ignored, with no effect on the in-flight operation.
- amt=0: full SHW cycles still elapse; dout=din, sticky=0.
- ROR with amt >= WIDTH: result equals rotation by amt mod WIDTH. This falls out naturally from the per-stage rotations.
- ASR with amt >= WIDTH-1: dout is all copies of the sign bit.
- dout and sticky are registered outputs, not combinational from the inputs.
- Inputs need not stay stable after the accept cycle.
- No state change occurs other than at clock edges.

Test Plan:
1. WIDTH=12, SHW=4. LSR: din=0xB5C, amt=3, start in cycle 0 -> busy cycles 1-4, done in cycle 5, dout=0x16B, sticky=1.
2. ASR: din=0x800, amt=11 -> dout=0xFFF, sticky=0. Repeat with din=0x801, amt=11 -> dout=0xFFF, sticky=1.
3. LSL: din=0x0F0, amt=5 -> dout=0xE00, sticky=0. Repeat with amt=0 -> dout=0x0F0 after full latency.
4. ROR: din=0x001, amt=13 -> dout=0x800 (rotate by 1), sticky=0. Repeat with din=0xABC, amt=12 -> dout=0xABC.
5. Handshake:
   - Start an operation; pulse start again in cycles 2 and 3 with different din -> ignored, first result correct.
   - Assert start in the done cycle -> second operation accepted, done again 5 cycles later.
6. Reset mid-operation: rst=1 in cycle 2 of an LSR -> next cycle busy=0, done=0, dout=0, sticky=0, and no done pulse follows. A subsequent start completes normally.
